// File: rtl/cmos_pkg.sv
// Shared constants for the CMOS pixel packer: pixel width and FIFO entry layout.
package cmos_pkg;

    localparam int PIX_W    = 16;
    localparam int DATA_LSB = 0;

    // A FIFO entry is {sof, eol, data}, so the flag bits sit just above the data field.
    function automatic int eol_bit(input int out_w);
        return DATA_LSB + out_w;
    endfunction

    function automatic int sof_bit(input int out_w);
        return DATA_LSB + out_w + 1;
    endfunction

endpackage

// File: rtl/cmos_pack_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever not empty.
module cmos_pack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Empty output reads as zero so the word bus is clean out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs RGB565 pixels into OUT_W-bit words tagged with start-of-frame / end-of-line,
// tracks line/frame geometry and queues words in a FWFT FIFO for the DDR write path.
module cmos_pixel_packer
    import cmos_pkg::*;
#(
    parameter int OUT_W      = 128,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               cmos_pclk,
    input  logic               sys_rst_n,
    input  logic               cmos_pclk_ce,
    input  logic               cmos_frame_vsync,
    input  logic               cmos_frame_valid,
    input  logic [PIX_W-1:0]   cmos_frame_data,
    output logic [OUT_W-1:0]   wr_data,
    output logic               wr_sof,
    output logic               wr_eol,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic               frame_done,
    output logic               line_err,
    output logic               overflow
);

    localparam int PPW   = OUT_W / PIX_W;
    localparam int IW    = $clog2(PPW);
    localparam int XW    = $clog2(H_ACTIVE + 2);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = OUT_W + 2;
    localparam int EOL_B = eol_bit(OUT_W);
    localparam int SOF_B = sof_bit(OUT_W);
    localparam logic [XW-1:0] X_SAT = XW'(H_ACTIVE + 1);

    logic               vsync_q;
    logic               valid_q;
    logic               active;
    logic [IW-1:0]      idx;
    logic [PIX_W-1:0]   lanes [PPW];
    logic [XW-1:0]      x_cnt;
    logic [YW-1:0]      y_cnt;
    logic               sof_pend;
    logic               done_pend;

    logic               vs_rise;
    logic               le_fall;
    logic               pix_en;
    logic               flush;
    logic               word_done;
    logic               eol_full;
    logic [OUT_W-1:0]   next_word;

    logic               vld_p1;
    logic               eol_p1;
    logic [OUT_W-1:0]   data_p1;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [EW-1:0]      fifo_head;
    logic               drop;

    assign vs_rise   = cmos_frame_vsync && !vsync_q;
    assign le_fall   = valid_q && !cmos_frame_valid;
    assign pix_en    = cmos_pclk_ce && cmos_frame_valid && active && !vs_rise;
    assign flush     = le_fall && active && !vs_rise;
    assign word_done = pix_en && (idx == IW'(PPW - 1));
    assign eol_full  = (int'(x_cnt) + 1 == H_ACTIVE);
    assign drop      = vld_p1 && (fifo_count == CW'(FIFO_DEPTH));

    always_comb begin
        next_word = '0;
        for (int k = 0; k < PPW; k++) begin
            next_word[k*PIX_W +: PIX_W] = (pix_en && idx == IW'(k)) ? cmos_frame_data : lanes[k];
        end
    end

    always_ff @(posedge cmos_pclk) begin
        if (!sys_rst_n) begin
            vsync_q    <= 1'b0;
            valid_q    <= 1'b0;
            active     <= 1'b0;
            idx        <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            sof_pend   <= 1'b0;
            done_pend  <= 1'b0;
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            vsync_q    <= cmos_frame_vsync;
            valid_q    <= cmos_frame_valid;
            vld_p1     <= word_done || (flush && idx != '0);
            frame_done <= done_pend;
            done_pend  <= 1'b0;
            if (drop) overflow <= 1'b1;

            if (vs_rise) begin
                active   <= 1'b1;
                idx      <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
                sof_pend <= 1'b1;
            end else begin
                // A dropped sof word keeps sof_pend so the next accepted word carries it.
                if (vld_p1 && !fifo_full) sof_pend <= 1'b0;
                if (pix_en) begin
                    idx <= word_done ? '0 : idx + 1'b1;
                    if (x_cnt != X_SAT) x_cnt <= x_cnt + 1'b1;
                end else if (flush) begin
                    idx   <= '0;
                    x_cnt <= '0;
                    if (x_cnt != XW'(H_ACTIVE)) line_err <= 1'b1;
                    if (y_cnt != YW'(V_ACTIVE)) begin
                        y_cnt <= y_cnt + 1'b1;
                        if (y_cnt == YW'(V_ACTIVE - 1)) done_pend <= 1'b1;
                    end
                end
            end
        end
    end

    // Stage p1: completed or flushed word waits one cycle before entering the FIFO.
    always_ff @(posedge cmos_pclk) begin
        if (vs_rise || word_done || flush) begin
            for (int k = 0; k < PPW; k++) lanes[k] <= '0;
        end else if (pix_en) begin
            lanes[idx] <= cmos_frame_data;
        end
        if (word_done || flush) begin
            data_p1 <= next_word;
            eol_p1  <= word_done ? eol_full : 1'b1;
        end
    end

    cmos_pack_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (cmos_pclk),
        .rst_n     (sys_rst_n),
        .push      (vld_p1),
        .push_data ({sof_pend, eol_p1, data_p1}),
        .pop       (wr_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign wr_data  = fifo_head[DATA_LSB +: OUT_W];
    assign wr_eol   = fifo_head[EOL_B];
    assign wr_sof   = fifo_head[SOF_B];

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Scoreboard bench for cmos_pixel_packer: reference model queues expected words, monitor compares.
module tb_cmos_pixel_packer;

    localparam int OUT_W = 64;
    localparam int H     = 8;
    localparam int V     = 2;
    localparam int DEPTH = 4;
    localparam int PPW   = OUT_W / 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic vs = 1'b0;
    logic fv = 1'b0;
    logic rdy = 1'b0;
    logic [15:0] pix = '0;

    logic [OUT_W-1:0] wr_data;
    logic wr_sof, wr_eol, wr_valid, frame_done, line_err, overflow;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    bit use_seq = 1'b1;
    logic [15:0] seq_val = 16'd1;
    bit mon_on = 1'b0;
    int acc_cnt = 0;
    int eol_cnt = 0;
    int fd_cnt = 0;
    logic [OUT_W-1:0] sof_word = '0;
    logic [OUT_W-1:0] last_word = '0;
    logic last_eol = 1'b0;

    always #5 clk = ~clk;

    cmos_pixel_packer #(
        .OUT_W(OUT_W), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH)
    ) dut (
        .cmos_pclk        (clk),
        .sys_rst_n        (rst_n),
        .cmos_pclk_ce     (ce),
        .cmos_frame_vsync (vs),
        .cmos_frame_valid (fv),
        .cmos_frame_data  (pix),
        .wr_data          (wr_data),
        .wr_sof           (wr_sof),
        .wr_eol           (wr_eol),
        .wr_valid         (wr_valid),
        .wr_ready         (rdy),
        .frame_done       (frame_done),
        .line_err         (line_err),
        .overflow         (overflow)
    );

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [OUT_W-1:0] data;
    } ent_t;

    ent_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: pixels gathered in a queue, words formed per the packing rules,
    // FIFO tracked only as an occupancy count against DEPTH.
    logic m_vs_q, m_fv_q, m_active, m_sof_pend, m_pend, m_pend_eol, m_done_pend;
    logic m_fd, m_le, m_ovf;
    logic [OUT_W-1:0] m_pend_data;
    logic [15:0] cur[$];
    int m_x, m_y, m_cnt;

    function automatic logic [OUT_W-1:0] pack_cur();
        logic [OUT_W-1:0] w = '0;
        foreach (cur[k]) w[k*16 +: 16] = cur[k];
        return w;
    endfunction

    always @(posedge clk) begin
        logic vs_rise, le_fall, pop, acc;
        if (!rst_n) begin
            m_vs_q = 0; m_fv_q = 0; m_active = 0; m_sof_pend = 0; m_pend = 0;
            m_pend_eol = 0; m_done_pend = 0; m_fd = 0; m_le = 0; m_ovf = 0;
            m_pend_data = '0; m_x = 0; m_y = 0; m_cnt = 0;
            cur.delete();
            exp_q.delete();
        end else begin
            pop = rdy && (m_cnt > 0);
            acc = 0;
            if (m_pend) begin
                if (m_cnt == DEPTH) m_ovf = 1;
                else begin
                    exp_q.push_back({m_sof_pend, m_pend_eol, m_pend_data});
                    acc = 1;
                    m_sof_pend = 0;
                end
            end
            m_cnt = m_cnt + int'(acc) - int'(pop);
            m_fd = m_done_pend;
            m_done_pend = 0;
            m_pend = 0;
            vs_rise = vs && !m_vs_q;
            le_fall = m_fv_q && !fv;
            if (vs_rise) begin
                m_active = 1; cur.delete(); m_x = 0; m_y = 0; m_sof_pend = 1;
            end else if (m_active) begin
                if (ce && fv) begin
                    cur.push_back(pix);
                    if (cur.size() == PPW) begin
                        m_pend = 1; m_pend_data = pack_cur(); m_pend_eol = (m_x + 1 == H);
                        cur.delete();
                    end
                    m_x++;
                end else if (le_fall) begin
                    if (cur.size() != 0) begin
                        m_pend = 1; m_pend_data = pack_cur(); m_pend_eol = 1;
                        cur.delete();
                    end
                    if (m_x != H) m_le = 1;
                    m_x = 0;
                    if (m_y < V) begin
                        m_y++;
                        if (m_y == V) m_done_pend = 1;
                    end
                end
            end
            m_vs_q = vs;
            m_fv_q = fv;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("wr_valid", wr_valid, exp_q.size() != 0);
            if (wr_valid && exp_q.size() != 0) begin
                check("wr_data", wr_data, exp_q[0].data);
                check("wr_sof", wr_sof, exp_q[0].sof);
                check("wr_eol", wr_eol, exp_q[0].eol);
                if (rdy) begin
                    acc_cnt++;
                    if (wr_eol) eol_cnt++;
                    if (wr_sof) sof_word = wr_data;
                    last_word = wr_data;
                    last_eol = wr_eol;
                    void'(exp_q.pop_front());
                end
            end
            check("frame_done", frame_done, m_fd);
            check("line_err", line_err, m_le);
            check("overflow", overflow, m_ovf);
            if (frame_done) fd_cnt++;
        end
    end

    task automatic step(input logic v, input logic f, input logic c, input logic [15:0] d);
        vs = v; fv = f; ce = c; pix = d;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
    endtask

    task automatic vsync_pulse();
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
    endtask

    // gate: 0 = every cycle enabled, 1 = enable alternates, 2 = random enable
    task automatic line(input int n, input int gate);
        int sent = 0;
        bit tog = 1'b1;
        logic [15:0] d;
        while (sent < n) begin
            bit en;
            en = (gate == 0) ? 1'b1 : (gate == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            if (en) begin
                d = use_seq ? seq_val : 16'($urandom);
                if (use_seq) seq_val++;
                sent++;
            end else begin
                d = 16'($urandom);
            end
            step(0, 1, en, d);
        end
        idle(3);
    endtask

    task automatic frame(input int gate);
        vsync_pulse();
        for (int l = 0; l < V; l++) line(H, gate);
    endtask

    initial begin
        int a0, e0, f0;
        rdy_mode = 0;
        rst_n = 1'b0;
        idle(3);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_data", wr_data, '0);
        check("rst_wr_sof", wr_sof, 1'b0);
        check("rst_wr_eol", wr_eol, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_line_err", line_err, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Nominal frame
        a0 = acc_cnt; e0 = eol_cnt; f0 = fd_cnt;
        use_seq = 1; seq_val = 16'd1;
        frame(0);
        idle(6);
        check("nom_words", acc_cnt - a0, 4);
        check("nom_eols", eol_cnt - e0, 2);
        check("nom_frame_done", fd_cnt - f0, 1);
        check("nom_sof_word", sof_word, 64'h0004_0003_0002_0001);
        check("nom_line_err", line_err, 1'b0);

        // Short line
        vsync_pulse();
        seq_val = 16'd1;
        line(6, 0);
        idle(3);
        check("short_word", last_word, 64'h0000_0000_0006_0005);
        check("short_eol", last_eol, 1'b1);
        check("short_line_err", line_err, 1'b1);
        line(8, 0);
        idle(3);
        check("short_err_sticky", line_err, 1'b1);

        // Randomized frames with random backpressure, gating and line lengths
        use_seq = 0;
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            vsync_pulse();
            for (int l = 0; l < V; l++) line($urandom_range(H - 2, H + 3), 2);
        end
        rdy_mode = 0;
        idle(12);

        // Backpressure then overflow
        rst_n = 1'b0; step(0, 0, 0, 16'h0); rst_n = 1'b1;
        rdy_mode = 1;
        use_seq = 1; seq_val = 16'd1;
        frame(0);
        idle(5);
        check("bp_overflow0", overflow, 1'b0);
        check("bp_valid", wr_valid, 1'b1);
        check("bp_head_hold", wr_data, 64'h0004_0003_0002_0001);
        check("bp_head_sof", wr_sof, 1'b1);
        line(8, 0);
        idle(2);
        check("bp_overflow1", overflow, 1'b1);
        a0 = acc_cnt;
        rdy_mode = 0;
        idle(10);
        check("bp_drained", acc_cnt - a0, 4);

        // Mid-line vsync discards the partial word
        vsync_pulse();
        line(8, 0);
        step(0, 1, 1, 16'hAAAA);
        step(0, 1, 1, 16'hBBBB);
        step(0, 1, 1, 16'hCCCC);
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        seq_val = 16'h0100;
        for (int l = 0; l < V; l++) line(H, 0);
        idle(4);
        check("midvs_sof_word", sof_word, 64'h0103_0102_0101_0100);

        // Gated pixels
        seq_val = 16'h0200;
        frame(1);
        idle(4);
        check("gated_sof_word", sof_word, 64'h0203_0202_0201_0200);

        // Reset mid-frame with words queued
        rdy_mode = 1;
        vsync_pulse();
        line(8, 0);
        idle(2);
        check("mr_queued", wr_valid, 1'b1);
        rst_n = 1'b0; step(0, 0, 0, 16'h0); rst_n = 1'b1;
        check("mr_valid_after", wr_valid, 1'b0);
        rdy_mode = 0;
        a0 = acc_cnt;
        line(8, 0);
        idle(3);
        check("mr_no_output", acc_cnt - a0, 0);
        seq_val = 16'h0300;
        frame(2);
        idle(8);
        check("mr_restart_sof", sof_word, 64'h0303_0302_0301_0300);
        check("final_empty", exp_q.size(), 0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
